ibm_bist_driver: RTL and testbench

- Sequential stimulus/response harness for the 48-in/17-out ibm benchmark netlist; drives its input vector and consumes its output vector.
- An LFSR generates 48-bit input patterns, one per cycle.
- A 17-bit MISR compacts the benchmark responses into a signature.
- An output-toggle accumulator provides a switching-activity figure for power-aware synthesis comparisons.
- Sits between a host/testbench control interface and the benchmark instance.

---
 rtl/ibm_bist_driver.sv | 171 +++++++++++++++++
 tb/tb_ibm_bist_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibm_bist_driver.sv
// rtl/ibm_bist_driver.sv - LFSR stimulus / MISR response harness for the 48-in/17-out ibm benchmark
module ibm_bist_driver #(
    parameter int              IN_W         = 48,
    parameter int              OUT_W        = 17,
    parameter int              NUM_PATTERNS = 1024,
    parameter int              DUT_LAT      = 0,
    parameter logic [IN_W-1:0] DEFAULT_SEED = 48'h0000_0000_0001,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [IN_W-1:0]  seed_in,
    output logic [IN_W-1:0]  pat_out,
    input  logic [OUT_W-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] pat_count
);

    localparam int ISS_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam int POP_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    lfsr;
    logic [IN_W-1:0]    lfsr_next;
    logic [OUT_W-1:0]   misr;
    logic [OUT_W-1:0]   misr_next;
    logic [OUT_W-1:0]   resp_prev;
    logic               have_prev;
    logic [ISS_W-1:0]   iss_cnt;
    logic [CNT_W-1:0]   tog_q;
    logic [CNT_W-1:0]   pc_q;
    logic [CNT_W:0]     tog_sum;
    logic [POP_W-1:0]   pop;
    logic               issue;
    logic               accept;
    logic               capture;
    logic               drain_empty;
    logic               last_issue;
    logic               ctl_window;

    assign ctl_window = (state_q == S_IDLE) || (state_q == S_DONE);
    assign last_issue = (iss_cnt == ISS_W'(NUM_PATTERNS - 1));
    assign lfsr_next  = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-2] ^ lfsr[20] ^ lfsr[19]};
    assign misr_next  = {misr[OUT_W-2:0], misr[OUT_W-1] ^ misr[13]} ^ resp_in;

    always_comb begin
        pop = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pop = pop + POP_W'(resp_in[i] ^ resp_prev[i]);
        end
    end

    assign tog_sum = {1'b0, tog_q} + (CNT_W + 1)'(pop);

    // The issue strobe travels through a shift register that mirrors the benchmark's register stages.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign capture     = issue;
            assign drain_empty = 1'b1;
        end else begin : g_pipe
            logic [DUT_LAT-1:0] pipe;
            logic [DUT_LAT-1:0] pipe_sh;

            assign pipe_sh     = pipe << 1;
            assign capture     = pipe[DUT_LAT-1];
            assign drain_empty = (pipe_sh == '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else begin
                    pipe <= pipe_sh | DUT_LAT'(issue);
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (last_issue) begin
                    state_d = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= DEFAULT_SEED;
            misr      <= '0;
            resp_prev <= '0;
            have_prev <= 1'b0;
            iss_cnt   <= '0;
            tog_q     <= '0;
            pc_q      <= '0;
        end else begin
            // A seed loaded alongside start is already in place for pattern 0 of the run.
            if (seed_load && ctl_window) begin
                lfsr <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
            end else if (issue) begin
                lfsr <= lfsr_next;
            end

            if (accept) begin
                misr      <= '0;
                tog_q     <= '0;
                pc_q      <= '0;
                iss_cnt   <= '0;
                have_prev <= 1'b0;
            end else begin
                if (issue) begin
                    iss_cnt <= iss_cnt + ISS_W'(1);
                end
                if (capture) begin
                    misr      <= misr_next;
                    pc_q      <= pc_q + CNT_W'(1);
                    resp_prev <= resp_in;
                    have_prev <= 1'b1;
                    if (have_prev) begin
                        tog_q <= tog_sum[CNT_W] ? {CNT_W{1'b1}} : tog_sum[CNT_W-1:0];
                    end
                end
            end
        end
    end

    assign pat_out      = lfsr;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign signature    = misr;
    assign toggle_count = tog_q;
    assign pat_count    = pc_q;

endmodule

// File: tb/tb_ibm_bist_driver.sv
// tb/tb_ibm_bist_driver.sv - directed table and sequence checks for ibm_bist_driver
module tb_ibm_bist_driver;

    logic clk, rst_n;
    logic seed_load_z;
    logic [47:0] seed_z;

    logic start_a, seed_load_a;
    logic [47:0] seed_in_a, pat_a, pat_s;
    logic [16:0] resp_a, sig_a, sig_s;
    logic busy_a, done_a, busy_s, done_s;
    logic [31:0] tog_a, pc_a;
    logic [4:0] tog_s, pc_s;

    logic start_b, busy_b, done_b;
    logic [47:0] pat_b;
    logic [16:0] resp_b, sig_b, r1, r2;
    logic [31:0] tog_b, pc_b;

    logic start_c, busy_c, done_c;
    logic [47:0] pat_c;
    logic [16:0] resp_c, sig_c;
    logic [31:0] tog_c, pc_c;

    int n_tests = 0;
    int n_fail  = 0;

    ibm_bist_driver #(.NUM_PATTERNS(4), .DUT_LAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seed_load(seed_load_a), .seed_in(seed_in_a),
        .pat_out(pat_a), .resp_in(resp_a), .busy(busy_a), .done(done_a), .signature(sig_a),
        .toggle_count(tog_a), .pat_count(pc_a));

    ibm_bist_driver #(.NUM_PATTERNS(4), .DUT_LAT(0), .CNT_W(5)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seed_load(seed_load_a), .seed_in(seed_in_a),
        .pat_out(pat_s), .resp_in(resp_a), .busy(busy_s), .done(done_s), .signature(sig_s),
        .toggle_count(tog_s), .pat_count(pc_s));

    ibm_bist_driver #(.NUM_PATTERNS(8), .DUT_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed_load(seed_load_z), .seed_in(seed_z),
        .pat_out(pat_b), .resp_in(resp_b), .busy(busy_b), .done(done_b), .signature(sig_b),
        .toggle_count(tog_b), .pat_count(pc_b));

    ibm_bist_driver #(.NUM_PATTERNS(1024), .DUT_LAT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .seed_load(seed_load_z), .seed_in(seed_z),
        .pat_out(pat_c), .resp_in(resp_c), .busy(busy_c), .done(done_c), .signature(sig_c),
        .toggle_count(tog_c), .pat_count(pc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] f_net(input logic [47:0] p);
        return p[16:0] ^ p[33:17] ^ 17'h0A5A5;
    endfunction

    // Two register stages standing in for a pipelined benchmark netlist.
    always_ff @(posedge clk) begin
        r1 <= f_net(pat_b);
        r2 <= r1;
    end
    assign resp_b = r2;
    assign resp_c = pat_c[16:0];

    function automatic logic [47:0] lfsr_nx(input logic [47:0] l);
        return {l[46:0], l[47] ^ l[46] ^ l[20] ^ l[19]};
    endfunction

    function automatic logic [16:0] misr_nx(input logic [16:0] m, input logic [16:0] r);
        return {m[15:0], m[16] ^ m[13]} ^ r;
    endfunction

    function automatic int popc(input logic [16:0] v);
        int c = 0;
        for (int i = 0; i < 17; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [47:0]       seed;
        logic [3:0][16:0]  resp;
        logic [16:0]       sig;
        logic [31:0]       tog;
        logic [4:0]        tog_sat;
    } rec_t;

    function automatic rec_t mk(input logic [47:0] seed, input logic [16:0] q0, input logic [16:0] q1,
                                input logic [16:0] q2, input logic [16:0] q3, input logic [16:0] sig,
                                input logic [31:0] tog, input logic [4:0] tog_sat);
        rec_t r;
        r.seed = seed;
        r.resp[0] = q0; r.resp[1] = q1; r.resp[2] = q2; r.resp[3] = q3;
        r.sig = sig; r.tog = tog; r.tog_sat = tog_sat;
        return r;
    endfunction

    rec_t tbl[5];

    initial begin
        int cyc, nbusy, bt;
        logic [47:0] ml, last_pat;
        logic [16:0] msig, prev;
        int mtog;

        tbl[0] = mk(48'h1,   17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h00005, 0,  0);
        tbl[1] = mk(48'h1,   17'h00000, 17'h1FFFF, 17'h00000, 17'h1FFFF, 17'h00003, 51, 31);
        tbl[2] = mk(48'hABC, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 0,  0);
        tbl[3] = mk(48'h5,   17'h00001, 17'h00002, 17'h00004, 17'h00008, 17'h00000, 6,  6);
        tbl[4] = mk(48'h1,   17'h00001, 17'h00000, 17'h00000, 17'h00000, 17'h00008, 1,  1);

        rst_n = 1'b0; seed_load_z = 1'b0; seed_z = '0;
        start_a = 0; seed_load_a = 0; seed_in_a = '0; resp_a = '0;
        start_b = 0; start_c = 0;
        tick(); tick();
        chk("rst_pat", pat_a, 48'h1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_sig", sig_a, 0);
        chk("rst_tog", tog_a, 0);
        chk("rst_pc", pc_a, 0);
        rst_n = 1'b1;
        tick();

        // Abort a 1024-pattern run at cycle 100 with an asynchronous reset.
        start_c = 1; tick(); start_c = 0;
        repeat (100) tick();
        chk("c_pc_at_100", pc_c, 100);
        chk("c_busy_at_100", busy_c, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("c_async_busy", busy_c, 0);
        chk("c_async_pc", pc_c, 0);
        chk("c_async_pat", pat_c, 48'h1);
        chk("c_async_sig", sig_c, 0);
        chk("c_async_tog", tog_c, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        start_c = 1; tick(); start_c = 0;
        cyc = 0;
        while (!done_c && cyc < 1100) begin tick(); cyc++; end
        chk("c_full_run_len", cyc, 1024);
        chk("c_full_pc", pc_c, 1024);

        for (int i = 0; i < 5; i++) begin
            seed_load_a = 1; seed_in_a = tbl[i].seed; start_a = 1;
            tick();
            seed_load_a = 0; start_a = 0;
            nbusy = 0;
            for (int k = 0; k < 4; k++) begin
                if (k == 0) chk($sformatf("row%0d_pat0", i), pat_a, tbl[i].seed);
                resp_a = tbl[i].resp[k];
                if (busy_a) nbusy++;
                tick();
            end
            chk($sformatf("row%0d_done", i), done_a, 1);
            chk($sformatf("row%0d_busy_cycles", i), nbusy, 4);
            chk($sformatf("row%0d_sig", i), sig_a, tbl[i].sig);
            chk($sformatf("row%0d_tog", i), tog_a, tbl[i].tog);
            chk($sformatf("row%0d_pc", i), pc_a, 4);
            chk($sformatf("row%0d_tog_sat", i), tog_s, tbl[i].tog_sat);
            chk($sformatf("row%0d_pc_s", i), pc_s, 4);
        end

        // Back-to-back run continues the LFSR; last pattern of the previous run was 0x8.
        last_pat = 48'h8;
        start_a = 1; tick(); start_a = 0;
        chk("b2b_first_pat", pat_a, lfsr_nx(last_pat));
        tick();
        chk("b2b_second_pat", pat_a, 48'h20);
        tick(); tick(); tick();
        chk("b2b_done", done_a, 1);

        // Tap check from a seed with bit 19 set; a seed_load while busy is ignored.
        seed_load_a = 1; seed_in_a = 48'h80000; start_a = 1; tick();
        seed_load_a = 0; start_a = 0;
        chk("tap_p0", pat_a, 48'h80000);
        seed_load_a = 1; seed_in_a = 48'h777;
        tick();
        seed_load_a = 0;
        chk("tap_p1", pat_a, 48'h100001);
        tick();
        chk("tap_p2", pat_a, 48'h200003);
        tick(); tick();
        chk("tap_done", done_a, 1);

        seed_load_a = 1; seed_in_a = 48'h1; start_a = 1; tick();
        seed_load_a = 0; start_a = 0;
        chk("seq_p0", pat_a, 48'h1);
        tick(); chk("seq_p1", pat_a, 48'h2);
        tick(); chk("seq_p2", pat_a, 48'h4);
        tick(); tick();
        seed_load_a = 1; seed_in_a = 48'h5; tick();
        chk("seed5", pat_a, 48'h5);
        seed_in_a = 48'h0; tick(); seed_load_a = 0;
        chk("seed0_default", pat_a, 48'h1);

        // Two-stage latency run with starts during busy.
        ml = 48'h1; msig = '0; mtog = 0; prev = '0;
        for (int k = 0; k < 8; k++) begin
            msig = misr_nx(msig, f_net(ml));
            if (k > 0) mtog += popc(f_net(ml) ^ prev);
            prev = f_net(ml);
            ml = lfsr_nx(ml);
        end
        start_b = 1; tick(); start_b = 0;
        cyc = 0; bt = 0;
        while (!done_b && cyc < 20) begin
            start_b = (cyc == 3 || cyc == 9);
            if (busy_b) bt++;
            tick();
            cyc++;
        end
        start_b = 0;
        chk("lat_done_cycle", cyc, 10);
        chk("lat_busy_cycles", bt, 10);
        chk("lat_sig", sig_b, msig);
        chk("lat_tog", tog_b, mtog);
        chk("lat_pc", pc_b, 8);
        chk("lat_pat_end", pat_b, ml);
        tick(); tick();
        chk("lat_done_hold", done_b, 1);
        chk("lat_pc_hold", pc_b, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
